// File: rtl/inj_scan_ctrl_if.sv
// Host/AFE-side bundle of the injection scan sequencer.
// master drives controls and HIT; slave is the sequencer.
interface inj_scan_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int TIM_W = 16
);
  logic             START;
  logic             ABORT;
  logic [CNT_W-1:0] N_INJ;
  logic [TIM_W-1:0] PERIOD;
  logic [TIM_W-1:0] WIDTH;
  logic             HIT;
  logic             INJ;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] INJ_CNT;
  logic [CNT_W-1:0] HIT_CNT;

  modport master (
    output START, ABORT, N_INJ, PERIOD, WIDTH, HIT,
    input  INJ, BUSY, DONE, INJ_CNT, HIT_CNT
  );

  modport slave (
    input  START, ABORT, N_INJ, PERIOD, WIDTH, HIT,
    output INJ, BUSY, DONE, INJ_CNT, HIT_CNT
  );
endinterface

// File: rtl/inj_scan_ctrl.sv
// Injection/hit scan sequencer: drives a train of INJ pulses
// and counts injections and synchronized hits per pulse.
module inj_scan_ctrl #(
  parameter int CNT_W = 16,
  parameter int TIM_W = 16
) (
  input  logic          CLK,
  input  logic          RST,
  inj_scan_ctrl_if.slave sc
);
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FIN
  } state_e;

  localparam logic [TIM_W-1:0] ONE_T = 1;
  localparam logic [CNT_W-1:0] ONE_C = 1;

  state_e           state_q, state_d;
  logic             hit_m_q, hit_s_q;
  logic [TIM_W-1:0] tmr_q, tmr_d;
  logic [TIM_W-1:0] wt_q, wt_d;
  logic [TIM_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             seen_q, seen_d;
  logic             inj_q;
  logic [TIM_W-1:0] w_eff, l_eff;

  // Effective high/low times; zero width and short periods clamp to 1.
  always_comb begin
    w_eff = (sc.WIDTH == '0) ? ONE_T : sc.WIDTH;
    l_eff = (sc.PERIOD > w_eff) ? (sc.PERIOD - w_eff) : ONE_T;
  end

  // Two-flop synchronizer for the asynchronous AFE hit latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_m_q <= 1'b0;
      hit_s_q <= 1'b0;
    end else begin
      hit_m_q <= sc.HIT;
      hit_s_q <= hit_m_q;
    end
  end

  // Next-state, timer and counter logic; ABORT overrides the scan.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    wt_d      = wt_q;
    lt_d      = lt_q;
    n_d       = n_q;
    inj_cnt_d = inj_cnt_q;
    hit_cnt_d = hit_cnt_q;
    seen_d    = seen_q;
    if (state_q != IDLE && sc.ABORT) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sc.START && !sc.ABORT) begin
            inj_cnt_d = '0;
            hit_cnt_d = '0;
            seen_d    = 1'b0;
            n_d       = sc.N_INJ;
            wt_d      = w_eff - ONE_T;
            lt_d      = l_eff - ONE_T;
            tmr_d     = '0;
            state_d   = (sc.N_INJ == '0) ? FIN : HIGH;
          end
        end
        HIGH: begin
          if (hit_s_q) seen_d = 1'b1;
          if (tmr_q == wt_q) begin
            tmr_d     = '0;
            state_d   = LOW;
            inj_cnt_d = inj_cnt_q + ONE_C;
            if (seen_q || hit_s_q) hit_cnt_d = hit_cnt_q + ONE_C;
            seen_d    = 1'b0;
          end else begin
            tmr_d = tmr_q + ONE_T;
          end
        end
        LOW: begin
          if (tmr_q == lt_q) begin
            tmr_d   = '0;
            state_d = (inj_cnt_q == n_q) ? FIN : HIGH;
          end else begin
            tmr_d = tmr_q + ONE_T;
          end
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, settings and counters; INJ registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      wt_q      <= '0;
      lt_q      <= '0;
      n_q       <= '0;
      inj_cnt_q <= '0;
      hit_cnt_q <= '0;
      seen_q    <= 1'b0;
      inj_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      wt_q      <= wt_d;
      lt_q      <= lt_d;
      n_q       <= n_d;
      inj_cnt_q <= inj_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      seen_q    <= seen_d;
      inj_q     <= (state_d == HIGH);
    end
  end

  assign sc.INJ     = inj_q;
  assign sc.BUSY    = (state_q != IDLE);
  assign sc.DONE    = (state_q == FIN);
  assign sc.INJ_CNT = inj_cnt_q;
  assign sc.HIT_CNT = hit_cnt_q;
endmodule
